// File: rtl/mem_access_pkg.sv
// Shared types for the load/store unit: access size, in-flight entry, buffered response, lane masks.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  localparam logic [3:0] LANE_NONE = 4'b0000;
  localparam logic [3:0] LANE_BYTE = 4'b0001;
  localparam logic [3:0] LANE_LO   = 4'b0011;
  localparam logic [3:0] LANE_HI   = 4'b1100;
  localparam logic [3:0] LANE_ALL  = 4'b1111;

  typedef struct packed {
    logic       write;
    size_t      size;
    logic       uns;
    logic [1:0] off;
    logic       error;
  } inflight_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } rsp_t;

  function automatic logic misaligned(size_t s, logic [1:0] off);
    return ((s == SZ_HALF) && off[0]) || ((s == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the block-memory port of mem_access_unit.
interface mem_access_unit_if #(parameter int ADDR_BITS = 7);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [ADDR_BITS-1:0] req_address;
  logic [31:0]          req_wr_data;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rd_data;
  logic                 rsp_error;

  logic [ADDR_BITS-1:0] mem_address;
  logic                 mem_rd_en;
  logic [3:0]           mem_wr_en;
  logic [31:0]          mem_wr_data;
  logic [31:0]          mem_rd_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_address, req_wr_data,
    input  rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_rd_data, rsp_error,
    output mem_address, mem_rd_en, mem_wr_en, mem_wr_data
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_address, req_wr_data,
    output rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rd_data, rsp_error,
    input  mem_address, mem_rd_en, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align: picks the addressed byte/half/word out of a memory word and extends it.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  size_t       i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);
  logic [31:0] w_sh;
  logic [15:0] w_half;

  assign w_sh   = i_word >> {i_off, 3'b000};
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_sh[7]}}, w_sh[7:0]};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      SZ_WORD: o_data = i_word;
      default: o_data = '0;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one-cycle memory access, in-flight stage, 2-entry in-order response FIFO.
// MEM_ACCESS_MISALIGN_TRAP_EN: misaligned half/word faults instead of being force-aligned.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_BITS = 7
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);
  size_t                w_size;
  logic [ADDR_BITS-1:0] w_addr;
  logic [1:0]           w_off;
  logic                 w_err;
  logic                 w_ready, w_acc, w_go;
  logic [3:0]           w_lanes;
  logic [31:0]          w_wdata;
  logic [31:0]          w_ld_data;
  logic                 w_rsp_vld, w_pop, w_push;
  rsp_t                 w_push_ent;

  inflight_t            r_inf;
  logic                 r_inf_vld;
  rsp_t                 r_buf [2];
  logic                 r_wr_ptr, r_rd_ptr;
  logic [1:0]           r_cnt;

  assign w_size = size_t'(bus.req_size);
  assign w_addr = bus.req_address;

  always_comb begin
    w_off = w_addr[1:0];
    w_err = (w_size == SZ_ILL);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if (misaligned(w_size, w_off)) w_err = 1'b1;
`else
    if (w_size == SZ_HALF) w_off[0] = 1'b0;
    if (w_size == SZ_WORD) w_off    = 2'b00;
`endif
  end

  // Occupancy plus in-flight never exceeds 2, so a push never lands in a full FIFO.
  assign w_rsp_vld = ~reset && (r_cnt != 2'd0);
  assign w_pop     = w_rsp_vld && bus.rsp_ready;
  assign w_ready   = ~reset && ((({1'b0, r_cnt} + {2'b00, r_inf_vld}) < 3'd2) || w_pop);
  assign w_acc     = bus.req_valid && w_ready;
  assign w_go      = w_acc && ~w_err;

  always_comb begin
    w_lanes = LANE_NONE;
    w_wdata = bus.req_wr_data;
    case (w_size)
      SZ_BYTE: begin
        w_lanes = LANE_BYTE << w_off;
        w_wdata = {4{bus.req_wr_data[7:0]}};
      end
      SZ_HALF: begin
        w_lanes = w_off[1] ? LANE_HI : LANE_LO;
        w_wdata = {2{bus.req_wr_data[15:0]}};
      end
      SZ_WORD: w_lanes = LANE_ALL;
      default: w_lanes = LANE_NONE;
    endcase
  end

  assign bus.req_ready   = w_ready;
  assign bus.mem_address = w_addr;
  assign bus.mem_rd_en   = w_go && ~bus.req_write;
  assign bus.mem_wr_en   = (w_go && bus.req_write) ? w_lanes : LANE_NONE;
  assign bus.mem_wr_data = w_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inf_vld <= 1'b0;
    end else begin
      r_inf_vld <= w_acc;
      if (w_acc) r_inf <= '{write: bus.req_write, size: w_size, uns: bus.req_unsigned,
                            off: w_off, error: w_err};
    end
  end

  mem_load_align u_align (
    .i_word     (bus.mem_rd_data),
    .i_off      (r_inf.off),
    .i_size     (r_inf.size),
    .i_unsigned (r_inf.uns),
    .o_data     (w_ld_data)
  );

  // Stores and faults answer through the same stage with zero data.
  assign w_push = r_inf_vld;
  always_comb begin
    w_push_ent.error = r_inf.error;
    w_push_ent.data  = (r_inf.write || r_inf.error) ? 32'd0 : w_ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= w_push_ent;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.rsp_valid   = w_rsp_vld;
  assign bus.rsp_rd_data = w_rsp_vld ? r_buf[r_rd_ptr].data : 32'd0;
  assign bus.rsp_error   = w_rsp_vld ? r_buf[r_rd_ptr].error : 1'b0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model, per-cycle compare, directed + random stimulus.
module tb_mem_access_unit;
  localparam int AB = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit_if #(.ADDR_BITS(AB)) bus ();
  mem_access_unit #(.ADDR_BITS(AB)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Environment memory: 1-cycle read latency, byte-enabled writes.
  logic [31:0] tmem [32];
  logic [7:0]  rmem [128];
  always @(posedge clk) begin
    if (mem_init)
      for (int i = 0; i < 32; i++) tmem[i] <= {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]};
    if (bus.mem_rd_en) bus.mem_rd_data <= tmem[bus.mem_address[6:2]];
    for (int i = 0; i < 4; i++)
      if (bus.mem_wr_en[i]) tmem[bus.mem_address[6:2]][8*i +: 8] <= bus.mem_wr_data[8*i +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int t; logic [31:0] d; logic e; } exp_t;
  exp_t q[$];
  int   rsp_cyc[$];

  // Reference model: outstanding requests in a queue; response k shows at accept+2 once at the head.
  always @(negedge clk) begin
    logic ev, er, acc, err, trap;
    logic [6:0] a;
    logic [1:0] sz;
    int nb;
    logic [3:0] wl;
    logic [31:0] wd, v;
    exp_t e;
    if (mem_init) begin
      for (int i = 0; i < 128; i++) rmem[i] = 8'($urandom);
      rmem[0] = 8'hBB; rmem[1] = 8'hAA; rmem[2] = 8'h99; rmem[3] = 8'h88;
    end
    if (bus.rsp_valid && bus.rsp_ready) rsp_cyc.push_back(cyc);
    if (reset) begin
      chk("rst_req_ready", {31'd0, bus.req_ready}, 0);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
      chk("rst_rsp_error", {31'd0, bus.rsp_error}, 0);
      chk("rst_rsp_data", bus.rsp_rd_data, 0);
      chk("rst_mem_rd_en", {31'd0, bus.mem_rd_en}, 0);
      chk("rst_mem_wr_en", {28'd0, bus.mem_wr_en}, 0);
      q.delete();
    end else begin
      ev = (q.size() > 0) && (q[0].t + 2 <= cyc);
      er = (q.size() < 2) || (ev && bus.rsp_ready);
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, er});
      chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, ev});
      if (ev) begin
        chk("rsp_rd_data", bus.rsp_rd_data, q[0].d);
        chk("rsp_error", {31'd0, bus.rsp_error}, {31'd0, q[0].e});
      end
      acc = bus.req_valid && er;
      a   = bus.req_address;
      sz  = bus.req_size;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      err = (sz == 2'd3);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      trap = 1'b1;
`else
      trap = 1'b0;
`endif
      if (!err && (a % nb) != 0) begin
        if (trap) err = 1'b1;
        else      a = a - 7'(a % nb);
      end
      wl = 4'd0; wd = 32'd0;
      if (acc && !err && bus.req_write) begin
        wl = 4'(((1 << nb) - 1) << a[1:0]);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = bus.req_wr_data[8*(i % nb) +: 8];
      end
      chk("mem_rd_en", {31'd0, bus.mem_rd_en}, {31'd0, acc && !err && !bus.req_write});
      chk("mem_wr_en", {28'd0, bus.mem_wr_en}, {28'd0, wl});
      if (acc && !err) chk("mem_address", {25'd0, bus.mem_address}, {25'd0, bus.req_address});
      if (wl != 4'd0) chk("mem_wr_data", bus.mem_wr_data, wd);
      if (ev && bus.rsp_ready) void'(q.pop_front());
      if (acc) begin
        v = 32'd0;
        if (!err && !bus.req_write) begin
          for (int k = 0; k < nb; k++) v = v | (32'(rmem[7'(a + 7'(k))]) << (8*k));
          if (!bus.req_unsigned && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        end
        if (!err && bus.req_write)
          for (int i = 0; i < 4; i++) if (wl[i]) rmem[{a[6:2], 2'(i)}] = wd[8*i +: 8];
        e.t = cyc; e.d = v; e.e = err;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic w, input logic [1:0] sz, input logic u, input logic [6:0] ad,
                      input logic [31:0] wd, output int t0, output logic [3:0] wen,
                      output logic [31:0] wdat);
    logic got = 1'b0;
    t0 = 0; wen = 4'd0; wdat = 32'd0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_address = ad; bus.req_wr_data = wd;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1; t0 = cyc; wen = bus.mem_wr_en; wdat = bus.mem_wr_data;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic xact(input logic w, input logic [1:0] sz, input logic u, input logic [6:0] ad,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output logic [3:0] wen, output logic [31:0] wdat);
    int t0;
    logic got = 1'b0;
    rd = 32'd0; er = 1'b0; lat = -1;
    send(w, sz, u, ad, wd, t0, wen, wdat);
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1; rd = bus.rsp_rd_data; er = bus.rsp_error; lat = cyc - t0;
      end
      @(posedge clk); #1;
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] rd, wdat;
    logic er;
    logic [3:0] wen;
    int lat, t0, n0;
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_address = 0; bus.req_wr_data = 0; bus.rsp_ready = 1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0; mem_init = 1'b0;

    xact(0, 2'd0, 0, 7'd1, 0, rd, er, lat, wen, wdat);
    chk("lit_byte_signed", rd, 32'hFFFFFFAA);
    chk("lit_latency", 32'(lat), 32'd2);
    xact(0, 2'd1, 1, 7'd2, 0, rd, er, lat, wen, wdat);
    chk("lit_half_unsigned", rd, 32'h00008899);
    xact(0, 2'd2, 0, 7'd0, 0, rd, er, lat, wen, wdat);
    chk("lit_word", rd, 32'h8899AABB);
    xact(1, 2'd0, 0, 7'd6, 32'h0000005C, rd, er, lat, wen, wdat);
    chk("lit_store_wen", {28'd0, wen}, 32'h4);
    chk("lit_store_wdata", wdat, 32'h5C5C5C5C);
    chk("lit_store_rsp", rd, 32'd0);
    xact(0, 2'd2, 1, 7'd4, 0, rd, er, lat, wen, wdat);
    chk("lit_store_readback", {24'd0, rd[23:16]}, 32'h5C);
    xact(0, 2'd2, 0, 7'd2, 0, rd, er, lat, wen, wdat);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    chk("lit_misalign_err", {31'd0, er}, 32'd1);
    chk("lit_misalign_data", rd, 32'd0);
`else
    chk("lit_misalign_err", {31'd0, er}, 32'd0);
    chk("lit_misalign_data", rd, 32'h8899AABB);
`endif
    xact(0, 2'd3, 0, 7'd0, 0, rd, er, lat, wen, wdat);
    chk("lit_illegal_err", {31'd0, er}, 32'd1);
    chk("lit_illegal_data", rd, 32'd0);

    n0 = rsp_cyc.size();
    for (int i = 0; i < 4; i++) send(0, 2'd2, 0, 7'(4*i), 0, t0, wen, wdat);
    repeat (4) begin @(posedge clk); #1; end
    chk("b2b_count", 32'(rsp_cyc.size() - n0), 32'd4);
    if (rsp_cyc.size() - n0 == 4) chk("b2b_consecutive", 32'(rsp_cyc[n0+3] - rsp_cyc[n0]), 32'd3);

    bus.rsp_ready = 0;
    n0 = rsp_cyc.size();
    send(0, 2'd0, 0, 7'd9, 0, t0, wen, wdat);
    send(0, 2'd1, 0, 7'd10, 0, t0, wen, wdat);
    bus.req_valid = 1'b1; bus.req_size = 2'd2; bus.req_address = 7'd12;
    repeat (3) begin
      @(negedge clk); chk("bp_ready_low", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1;
    send(0, 2'd2, 0, 7'd12, 0, t0, wen, wdat);
    repeat (5) begin @(posedge clk); #1; end
    chk("bp_no_loss", 32'(rsp_cyc.size() - n0), 32'd3);

    send(0, 2'd2, 0, 7'd0, 0, t0, wen, wdat);
    n0 = rsp_cyc.size();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk); chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_discard", 32'(rsp_cyc.size() - n0), 32'd0);

    for (int i = 0; i < 800; i++) begin
      bus.req_valid    = ($urandom_range(0, 3) != 0);
      bus.req_write    = $urandom_range(0, 1) == 1;
      bus.req_size     = 2'($urandom_range(0, 3));
      bus.req_unsigned = $urandom_range(0, 1) == 1;
      bus.req_address  = 7'($urandom_range(0, 127));
      bus.req_wr_data  = $urandom;
      bus.rsp_ready    = ($urandom_range(0, 3) != 0);
      reset            = (i == 400 || i == 401);
      @(posedge clk); #1;
    end
    bus.req_valid = 0; bus.rsp_ready = 1;
    repeat (6) begin @(posedge clk); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
